nn_c2_serial_negator: RTL and testbench
=======================================

Name: nn_c2_serial_negator

Overview:
- Parametrised, bit-serial N-digit two's complement negator / absolute-value unit with start/done handshake.
- Operand is captured once, then processed LSB-first at one digit per clock using the rule "copy up to and including the first 1, invert thereafter".
- The result is held until the next operation.
- Intended for area-constrained datapaths in the integer_utils family, where a full-width incrementer is not wanted.

Parameters:
- N, 8, operand/result width in binary digits; legal range N >= 2.

Ports:
- clock  input  1  system clock, rising-edge active
- reset_  input  1  asynchronous, active-low reset
- x  input  N  two's complement operand, sampled only on the accepting edge
- mode  input  1  0 = negate (z = -x); 1 = absolute value (z = |x|); sampled with x
- start  input  1  request; accepted on a rising edge where start=1 and ready=1
- ready  output  1  unit idle, able to accept start
- z  output  N  result register
- ow  output  1  overflow flag, valid with done and held with z
- done  output  1  one-cycle pulse, result valid

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (clock, reset_).
- Reset (reset_=0, any time, including mid-operation):
  - state=IDLE, ready=1, done=0, z=0, ow=0.
  - Internal shift register, digit counter and seen_one flag are cleared.
  - In-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, done=0.
  - On edge with start=1: capture x into shift register sr, mode into m.
  - Set inv = (m==0) | x[N-1]. Absolute value of a non-negative x passes through unchanged.
  - Capture sign bit xs = x[N-1]; clear seen_one and counter; go to SHIFT.
- SHIFT (exactly N edges, ready=0, done=0). Each edge:
  - b = sr[0]; out = (inv & seen_one) ? ~b : b; seen_one <= seen_one | b.
  - sr shifts right; out enters the result register from the MSB side, so after N edges the result is aligned with z[0] = LSB.
  - Counter increments; after the N-th edge go to DONE.
- z update: z is updated only on the transition into DONE. It holds its previous value during SHIFT; no partial results are visible.
- DONE (one cycle):
  - done=1, ready=0; z and ow valid; next edge goes to IDLE.
- Latency:
  - done is high in the cycle following the N-th edge after the accepting edge.
  - ready returns 1 the cycle after done.
  - Minimum spacing between accepted starts is N+2 edges.
- Overflow:
  - ow = inv & xs & z_raw[N-1], where z_raw is the unsaturated serial result.
  - Only x = 100...0 (-2^(N-1)) with inversion active sets ow.
- Boundary conditions:
  - x=0 with negate: z=0, ow=0.
  - start=1 while ready=0 is ignored; no queuing.
  - start held high continuously: a new operation is accepted on each IDLE cycle.
  - x/mode changes after acceptance have no effect.
- Hold: z/ow hold their values after DONE until the next completion or reset.

Optional Feature:
- Macro: NEG_SATURATE_EN.
- Defined: on overflow, z = 011...1 (+2^(N-1)-1) instead of 100...0; ow still 1. All other results and timing are unchanged.
- Undefined: z = z_raw (wrap-around; -2^(N-1) maps to itself).

Test Plan:
- N=8, reset_ pulsed low mid-SHIFT (start x=8'h05 mode=0, reset after 3 edges) -> immediately z=0, ow=0, done=0, ready=1; no done pulse follows.
- N=8, x=8'h05 mode=0 -> done exactly 8 edges after accept, z=8'hFB, ow=0, ready=0 from accept through done cycle.
- N=8, x=8'h80 mode=0 -> ow=1; z=8'h80 (macro undefined) / 8'h7F (NEG_SATURATE_EN); same for mode=1.
- N=8, mode=1: x=8'hF6 -> z=8'h0A, ow=0; x=8'h2A -> z=8'h2A, ow=0; x=8'h00 mode=0 -> z=8'h00, ow=0.
- N=8, start held high, x changes every cycle -> operations accepted every 10 edges. Starts during busy are ignored. Each result matches the x captured at its accepting edge; z stable between done pulses.
- N=16 and N=2 instances: x=16'h0001 -> 16'hFFFF; x=2'b10 -> ow=1; x=2'b01 -> 2'b11. Latency is N edges to done.

Source files
------------

// File: rtl/nn_c2_serial_negator.sv
// nn_c2_serial_negator
//   Bit-serial two's complement negator / absolute-value unit.
//   The operand is captured once on the accepting edge. It is then processed
//   LSB-first at one digit per clock with the rule "copy up to and including
//   the first 1, invert thereafter".
//   The result register z and the overflow flag ow are loaded only on the
//   transition into DONE. They hold until the next completion or reset.
//
//   Optional feature (compile-time macro NEG_SATURATE_EN):
//     When the macro is defined, an overflowing result saturates to +2^(N-1)-1.
//     When it is undefined, the result wraps, so -2^(N-1) maps to itself.
//
// Parameters
//   N      operand/result width in binary digits (N >= 2)
// Ports
//   clock  system clock, rising-edge active
//   reset_ asynchronous active-low reset
//   x      two's complement operand, sampled on the accepting edge
//   mode   0 = negate (z = -x), 1 = absolute value (z = |x|); sampled with x
//   start  request, accepted on an edge where start=1 and ready=1
//   ready  unit idle, able to accept start
//   z      result register
//   ow     overflow flag, valid with done and held with z
//   done   one-cycle pulse, result valid
module nn_c2_serial_negator #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [N-1:0] x,
  input  logic         mode,
  input  logic         start,
  output logic         ready,
  output logic [N-1:0] z,
  output logic         ow,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sr;        // operand, consumed LSB-first
  logic [N-1:0]   acc;       // partial result, filled from the MSB side
  logic [CW-1:0]  cnt;       // digit counter
  logic           seen_one;
  logic           inv;       // inversion active for this operation
  logic           xs;        // operand sign

  logic           b;
  logic           out_bit;
  logic           last_digit;
  logic [N-1:0]   z_raw;
  logic           ow_raw;

  // Overflow only ever produces 100...0; saturation replaces it with the
  // largest positive value. In wrap mode the raw value is kept either way.
  function automatic logic [N-1:0] saturate(input logic [N-1:0] v, input logic o);
`ifdef NEG_SATURATE_EN
    saturate = o ? {1'b0, {(N-1){1'b1}}} : v;
`else
    if (o) saturate = v;
    else   saturate = v;
`endif
  endfunction

  always_comb begin
    b          = sr[0];
    out_bit    = (inv & seen_one) ? ~b : b;
    z_raw      = {out_bit, acc[N-1:1]};
    ow_raw     = inv & xs & z_raw[N-1];
    last_digit = (cnt == CW'(N-1));
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
      inv      <= 1'b0;
      xs       <= 1'b0;
      z        <= '0;
      ow       <= 1'b0;
    end else begin
      case (state)
        // capture stage: absolute value of a non-negative operand passes through
        IDLE: begin
          if (start) begin
            sr       <= x;
            inv      <= ~mode | x[N-1];
            xs       <= x[N-1];
            seen_one <= 1'b0;
            cnt      <= '0;
          end
        end
        // serial stage: one digit per edge, result published only at the end
        SHIFT: begin
          sr       <= sr >> 1;
          acc      <= z_raw;
          seen_one <= seen_one | b;
          cnt      <= cnt + 1'b1;
          if (last_digit) begin
            z  <= saturate(z_raw, ow_raw);
            ow <= ow_raw;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_c2_serial_negator.sv
module tb_nn_c2_serial_negator;

  logic clock = 1'b0;
  logic reset_ = 1'b0;
  always #5 clock = ~clock;

  // channel 0: N=8, channel 1: N=16, channel 2: N=2
  logic [15:0] x_d [3];
  logic        md_d[3];
  logic        st_d[3];

  logic [7:0]  z8;
  logic [15:0] z16;
  logic [1:0]  z2;
  logic        ow_o[3], rdy_o[3], dn_o[3];
  logic [15:0] z_o[3];

  always_comb begin
    z_o[0] = {8'h00, z8};
    z_o[1] = z16;
    z_o[2] = {14'h0, z2};
  end

  nn_c2_serial_negator #(.N(8)) dut8 (
    .clock(clock), .reset_(reset_), .x(x_d[0][7:0]), .mode(md_d[0]), .start(st_d[0]),
    .ready(rdy_o[0]), .z(z8), .ow(ow_o[0]), .done(dn_o[0]));

  nn_c2_serial_negator #(.N(16)) dut16 (
    .clock(clock), .reset_(reset_), .x(x_d[1]), .mode(md_d[1]), .start(st_d[1]),
    .ready(rdy_o[1]), .z(z16), .ow(ow_o[1]), .done(dn_o[1]));

  nn_c2_serial_negator #(.N(2)) dut2 (
    .clock(clock), .reset_(reset_), .x(x_d[2][1:0]), .mode(md_d[2]), .start(st_d[2]),
    .ready(rdy_o[2]), .z(z2), .ow(ow_o[2]), .done(dn_o[2]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wid(input int ch);
    return (ch == 0) ? 8 : (ch == 1) ? 16 : 2;
  endfunction

  // Arithmetic reference: {ow, z}
  function automatic logic [16:0] model(input int n, input logic [15:0] xx, input logic md);
    logic [31:0] mask, xv, r;
    logic neg, inv, o;
    mask = (32'h1 << n) - 1;
    xv   = {16'h0, xx} & mask;
    neg  = xv[n-1];
    inv  = !md || neg;
    r    = inv ? ((~xv + 1) & mask) : xv;
    o    = inv && (xv == (32'h1 << (n-1)));
`ifdef NEG_SATURATE_EN
    if (o) r = mask >> 1;
`endif
    return {o, r[15:0]};
  endfunction

  logic [16:0] q0[$], q1[$], q2[$];

  task automatic sb_push(input int ch, input logic [16:0] v);
    case (ch)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int ch, output logic [16:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    case (ch)
      0: if (q0.size() > 0) v = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) v = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) v = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Bench-side timing model: busy counts down N+1 cycles from acceptance;
  // done is expected when busy==1, ready when busy==0.
  int          busy[3];
  logic [15:0] zl[3];
  logic        owl[3];

  initial for (int i = 0; i < 3; i++) begin busy[i] = 0; zl[i] = '0; owl[i] = 1'b0; end

  always @(negedge clock) begin
    logic [16:0] e;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      if (!reset_) begin
        busy[i] = 0;
        case (i) 0: q0.delete(); 1: q1.delete(); default: q2.delete(); endcase
        chk($sformatf("rst_ready%0d", i), rdy_o[i], 1);
        chk($sformatf("rst_done%0d", i), dn_o[i], 0);
        chk($sformatf("rst_z%0d", i), z_o[i], 0);
        chk($sformatf("rst_ow%0d", i), ow_o[i], 0);
        zl[i]  = '0;
        owl[i] = 1'b0;
      end else begin
        chk($sformatf("ready%0d", i), rdy_o[i], busy[i] == 0);
        chk($sformatf("done%0d", i), dn_o[i], busy[i] == 1);
        if (busy[i] == 1) begin
          sb_pop(i, e, ok);
          chk($sformatf("sb_nonempty%0d", i), ok, 1);
          chk($sformatf("z%0d", i), z_o[i], e[15:0]);
          chk($sformatf("ow%0d", i), ow_o[i], e[16]);
        end else begin
          chk($sformatf("z_hold%0d", i), z_o[i], zl[i]);
          chk($sformatf("ow_hold%0d", i), ow_o[i], owl[i]);
        end
        zl[i]  = z_o[i];
        owl[i] = ow_o[i];
        if (busy[i] > 0) busy[i] = busy[i] - 1;
        else if (st_d[i]) begin
          sb_push(i, model(wid(i), x_d[i], md_d[i]));
          busy[i] = wid(i) + 1;
        end
      end
    end
  end

  task automatic do_op(input int ch, input logic [15:0] xx, input logic md);
    @(posedge clock); #1;
    x_d[ch] = xx; md_d[ch] = md; st_d[ch] = 1'b1;
    @(posedge clock); #1;
    st_d[ch] = 1'b0;
    x_d[ch]  = 16'($urandom);
    md_d[ch] = 1'($urandom);
    repeat (wid(ch) + 2) @(posedge clock);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin x_d[i] = '0; md_d[i] = 1'b0; st_d[i] = 1'b0; end
    repeat (3) @(posedge clock);
    #2 reset_ = 1'b1;

    do_op(0, 16'h05, 1'b0);
    do_op(0, 16'h80, 1'b0);
    do_op(0, 16'h80, 1'b1);
    do_op(0, 16'hF6, 1'b1);
    do_op(0, 16'h2A, 1'b1);
    do_op(0, 16'h00, 1'b0);
    do_op(0, 16'h7F, 1'b0);

    // start pulses while busy are ignored
    @(posedge clock); #1;
    x_d[0] = 16'h11; md_d[0] = 1'b0; st_d[0] = 1'b1;
    @(posedge clock); #1;
    st_d[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1 x_d[0] = 16'h33; st_d[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1 st_d[0] = 1'b0;
    repeat (10) @(posedge clock);

    // start held high, operand changing every cycle
    @(posedge clock); #1;
    st_d[0] = 1'b1;
    repeat (42) begin
      x_d[0]  = 16'($urandom);
      md_d[0] = 1'($urandom);
      @(posedge clock); #1;
    end
    st_d[0] = 1'b0;
    repeat (12) @(posedge clock);

    do_op(1, 16'h0001, 1'b0);
    do_op(1, 16'h8000, 1'b1);
    do_op(1, 16'hFF00, 1'b1);
    do_op(1, 16'h1234, 1'b0);
    do_op(2, 16'h2, 1'b0);
    do_op(2, 16'h1, 1'b0);
    do_op(2, 16'h2, 1'b1);
    do_op(2, 16'h3, 1'b1);

    // asynchronous reset in the middle of an operation
    @(posedge clock); #1;
    x_d[0] = 16'h05; md_d[0] = 1'b0; st_d[0] = 1'b1;
    @(posedge clock); #1;
    st_d[0] = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_ = 1'b0;
    #1;
    chk("midrst_z", z_o[0], 0);
    chk("midrst_ow", ow_o[0], 0);
    chk("midrst_done", dn_o[0], 0);
    chk("midrst_ready", rdy_o[0], 1);
    repeat (2) @(posedge clock);
    #2 reset_ = 1'b1;
    repeat (14) @(posedge clock);

    do_op(0, 16'hC3, 1'b0);
    repeat (3) @(posedge clock);

    chk("sb_drained0", q0.size(), 0);
    chk("sb_drained1", q1.size(), 0);
    chk("sb_drained2", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
